// File: rtl/dmem_mmio.sv
// dmem_mmio: data-memory stage with word RAM and an MMIO window.
//   RAM at byte addresses 0 .. RAM_WORDS*4-1 (no reset on contents).
//   MMIO_BASE+0x0 TXDATA : write pushes a byte into the TX FIFO, reads 0.
//   MMIO_BASE+0x4 STATUS : {count[8:4], overflow[2], empty[1], full[0]}.
//   MMIO_BASE+0x8 CYCLE  : free-running cycle counter, loadable.
// Optional feature macro: DMEM_MMIO_CYCLE_EN enables the CYCLE counter;
// when undefined CYCLE reads 0 and writes are ignored.
module dmem_mmio #(
   parameter int          RAM_WORDS  = 64,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int          AW         = $clog2(RAM_WORDS);
   localparam int          PW         = $clog2(FIFO_DEPTH);
   localparam int          CW         = PW + 1;
   localparam logic [31:0] RAM_BYTES  = 32'(RAM_WORDS * 4);
   localparam logic [31:0] TXDATA_ADR = MMIO_BASE;
   localparam logic [31:0] STATUS_ADR = MMIO_BASE + 32'h4;
   localparam logic [31:0] CYCLE_ADR  = MMIO_BASE + 32'h8;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   logic          ram_hit, tx_hit, st_hit, cyc_hit;
   logic [AW-1:0] ram_idx;
   logic          ram_we, push, pop, accept, ovf_set, st_we;
   logic          full, empty;

   logic [31:0]   ram_q  [RAM_WORDS];
   logic [7:0]    fifo_q [FIFO_DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [31:0]   cycle_rd;
   logic [31:0]   status_word;

   // Byte-lane bits are never decoded; word access only.
   logic          unused_adr;
   assign unused_adr = ^DataAdr[1:0];

   // Address decode and write strobes.
   always_comb begin
      ram_hit = (DataAdr < RAM_BYTES);
      tx_hit  = (DataAdr[31:2] == TXDATA_ADR[31:2]);
      st_hit  = (DataAdr[31:2] == STATUS_ADR[31:2]);
      cyc_hit = (DataAdr[31:2] == CYCLE_ADR[31:2]);
      ram_idx = DataAdr[AW+1:2];
      ram_we  = MemWrite && ram_hit;
      push    = MemWrite && tx_hit;
      st_we   = MemWrite && st_hit;
   end

   // RAM array: contents survive reset, so no reset branch.
   always_ff @(posedge clk) begin
      if (ram_we) ram_q[ram_idx] <= WriteData;
   end

   // FIFO control: a push into a full FIFO is still taken when the head pops.
   always_comb begin
      full     = (count_q == FULL_CNT);
      empty    = (count_q == '0);
      pop      = tx_valid && tx_ready;
      accept   = push && (!full || pop);
      ovf_set  = push && full && !pop;
      wr_ptr_d = accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop    ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(accept) - CW'(pop);
      ovf_d    = ovf_q;
      if (st_we && WriteData[2]) ovf_d = 1'b0;
      if (ovf_set)               ovf_d = 1'b1;
   end

   // FIFO storage; validity is tracked by count, so entries need no reset.
   always_ff @(posedge clk) begin
      if (accept) fifo_q[wr_ptr_q] <= WriteData[7:0];
   end

   // FIFO pointers, count and sticky overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Head byte is forced to zero when empty so reset shows 8'h00.
   assign tx_valid = !empty;
   assign tx_data  = tx_valid ? fifo_q[rd_ptr_q] : 8'h00;

`ifdef DMEM_MMIO_CYCLE_EN
   logic [31:0] cycle_q, cycle_d;

   // Cycle counter: a store loads it, otherwise it increments and wraps.
   always_comb begin
      cycle_d = (MemWrite && cyc_hit) ? WriteData : cycle_q + 32'd1;
   end

   // Cycle counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cycle_q <= '0;
      else        cycle_q <= cycle_d;
   end

   assign cycle_rd = cycle_q;
`else
   assign cycle_rd = '0;
`endif

   // Load data mux; TXDATA and unmapped addresses read as zero.
   always_comb begin
      status_word      = '0;
      status_word[0]   = full;
      status_word[1]   = empty;
      status_word[2]   = ovf_q;
      status_word[8:4] = 5'(count_q);
      ReadData         = '0;
      if (ram_hit)      ReadData = ram_q[ram_idx];
      else if (st_hit)  ReadData = status_word;
      else if (cyc_hit) ReadData = cycle_rd;
   end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed self-checking bench for dmem_mmio (default parameters).
module tb_dmem_mmio;

   localparam logic [31:0] TXDATA = 32'h0000_1000;
   localparam logic [31:0] STATUS = 32'h0000_1004;
   localparam logic [31:0] CYCLE  = 32'h0000_1008;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int checks = 0;
   int errors = 0;

   dmem_mmio dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .DataAdr   (DataAdr),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready)
   );

   always #5 clk = ~clk;

   // One store: drive at a falling edge, commit at the rising edge.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      MemWrite  = 1'b1;
      DataAdr   = a;
      WriteData = d;
      @(negedge clk);
      MemWrite  = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      MemWrite = 1'b0;
      DataAdr  = a;
      #1 d = ReadData;
   endtask

   task automatic test_reset;
      logic [31:0] r;
      reset = 1'b0; MemWrite = 1'b0; DataAdr = STATUS; WriteData = '0; tx_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (ReadData !== 32'h2) begin errors++; $display("FAIL reset_status got %h exp %h", ReadData, 32'h2); end
      checks++;
      if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
         errors++; $display("FAIL reset_tx got v=%b d=%h exp v=0 d=00", tx_valid, tx_data);
      end
      DataAdr = CYCLE;
      #1;
      checks++;
      if (ReadData !== 32'h0) begin errors++; $display("FAIL reset_cycle got %h exp 0", ReadData); end
      @(negedge clk);
      reset = 1'b1;
      do_read(32'h0000_2000, r);
      checks++;
      if (r !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h exp 0", r); end
   endtask

   task automatic test_ram;
      logic [31:0] r;
      do_write(32'h10, 32'hDEAD_BEEF);
      do_read(32'h10, r);
      checks++;
      if (r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd got %h exp deadbeef", r); end
      do_read(32'h13, r);
      checks++;
      if (r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd_13 got %h exp deadbeef", r); end
      do_write(32'h20, 32'h1111_1111);
      // Same-cycle read-during-write shows the old word.
      @(negedge clk);
      MemWrite = 1'b1; DataAdr = 32'h20; WriteData = 32'h2222_2222;
      #1;
      checks++;
      if (ReadData !== 32'h1111_1111) begin errors++; $display("FAIL ram_rdw got %h exp 11111111", ReadData); end
      @(negedge clk);
      MemWrite = 1'b0;
      #1;
      checks++;
      if (ReadData !== 32'h2222_2222) begin errors++; $display("FAIL ram_new got %h exp 22222222", ReadData); end
      do_write(32'h0000_2000, 32'h1234_5678);
      do_read(32'h0000_2000, r);
      checks++;
      if (r !== 32'h0) begin errors++; $display("FAIL unmapped_wr got %h exp 0", r); end
      do_read(32'h100, r);
      checks++;
      if (r !== 32'h0) begin errors++; $display("FAIL ram_edge got %h exp 0", r); end
   endtask

   task automatic test_fifo_order;
      logic [31:0] r;
      logic [7:0]  exp_b;
      tx_ready = 1'b0;
      do_write(TXDATA, 32'hFFFF_FF41);
      do_write(TXDATA, 32'h0000_0042);
      do_write(TXDATA, 32'h0000_0043);
      do_read(STATUS, r);
      checks++;
      if (r !== 32'h30) begin errors++; $display("FAIL fifo3_status got %h exp 30", r); end
      checks++;
      if (tx_data !== 8'h41 || tx_valid !== 1'b1) begin
         errors++; $display("FAIL fifo3_head got v=%b d=%h exp v=1 d=41", tx_valid, tx_data);
      end
      do_read(TXDATA, r);
      checks++;
      if (r !== 32'h0 || tx_data !== 8'h41) begin
         errors++; $display("FAIL txdata_rd got %h head %h exp 0 head 41", r, tx_data);
      end
      @(negedge clk);
      tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         exp_b = 8'h41 + 8'(i);
         checks++;
         if (tx_data !== exp_b || tx_valid !== 1'b1) begin
            errors++; $display("FAIL drain%0d got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, exp_b);
         end
         @(negedge clk);
      end
      tx_ready = 1'b0;
      DataAdr = STATUS;
      #1;
      checks++;
      if (ReadData !== 32'h2 || tx_valid !== 1'b0) begin
         errors++; $display("FAIL drained_status got %h v=%b exp 2 v=0", ReadData, tx_valid);
      end
   endtask

   task automatic test_overflow;
      logic [31:0] r;
      tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) do_write(TXDATA, 32'h60 + 32'(i));
      do_read(STATUS, r);
      checks++;
      if (r !== 32'h85) begin errors++; $display("FAIL ovf_status got %h exp 85", r); end
      checks++;
      if (tx_data !== 8'h60) begin errors++; $display("FAIL ovf_head got %h exp 60", tx_data); end
      do_write(STATUS, 32'h4);
      do_read(STATUS, r);
      checks++;
      if (r !== 32'h81) begin errors++; $display("FAIL ovf_clear got %h exp 81", r); end
   endtask

   task automatic test_full_push_pop;
      logic [31:0] r;
      logic [7:0]  exp_b;
      @(negedge clk);
      tx_ready = 1'b1; MemWrite = 1'b1; DataAdr = TXDATA; WriteData = 32'h55;
      @(negedge clk);
      tx_ready = 1'b0; MemWrite = 1'b0; DataAdr = STATUS;
      #1;
      checks++;
      if (ReadData !== 32'h81) begin errors++; $display("FAIL fullpp_status got %h exp 81", ReadData); end
      @(negedge clk);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         exp_b = (i == 7) ? 8'h55 : 8'h61 + 8'(i);
         checks++;
         if (tx_data !== exp_b || tx_valid !== 1'b1) begin
            errors++; $display("FAIL fullpp%0d got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, exp_b);
         end
         @(negedge clk);
      end
      tx_ready = 1'b0;
      do_read(STATUS, r);
      checks++;
      if (r !== 32'h2) begin errors++; $display("FAIL fullpp_empty got %h exp 2", r); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] r;
      do_write(TXDATA, 32'h70);
      @(negedge clk);
      tx_ready = 1'b1; MemWrite = 1'b1; DataAdr = TXDATA; WriteData = 32'h71;
      #1;
      checks++;
      if (tx_data !== 8'h70) begin errors++; $display("FAIL b2b_head0 got %h exp 70", tx_data); end
      @(negedge clk);
      tx_ready = 1'b0; MemWrite = 1'b0; DataAdr = STATUS;
      #1;
      checks++;
      if (ReadData !== 32'h10 || tx_data !== 8'h71) begin
         errors++; $display("FAIL b2b got %h head %h exp 10 head 71", ReadData, tx_data);
      end
      @(negedge clk);
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      do_read(STATUS, r);
      checks++;
      if (r !== 32'h2) begin errors++; $display("FAIL b2b_empty got %h exp 2", r); end
   endtask

   task automatic test_cycle;
      logic [31:0] exp_c [4];
`ifdef DMEM_MMIO_CYCLE_EN
      exp_c[0] = 32'hFFFF_FFFE; exp_c[1] = 32'hFFFF_FFFF;
      exp_c[2] = 32'h0000_0000; exp_c[3] = 32'h0000_0001;
`else
      for (int i = 0; i < 4; i++) exp_c[i] = 32'h0;
`endif
      do_write(CYCLE, 32'hFFFF_FFFE);
      DataAdr = CYCLE;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (ReadData !== exp_c[i]) begin
            errors++; $display("FAIL cycle%0d got %h exp %h", i, ReadData, exp_c[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_drain;
      logic [31:0] r;
      for (int i = 0; i < 4; i++) do_write(TXDATA, 32'hA0 + 32'(i));
      @(negedge clk);
      tx_ready = 1'b1;
      #1;
      checks++;
      if (tx_data !== 8'hA0) begin errors++; $display("FAIL rst_head got %h exp a0", tx_data); end
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      checks++;
      if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
         errors++; $display("FAIL rst_async got v=%b d=%h exp v=0 d=00", tx_valid, tx_data);
      end
      @(negedge clk);
      reset = 1'b1; tx_ready = 1'b0;
      do_read(STATUS, r);
      checks++;
      if (r !== 32'h2) begin errors++; $display("FAIL rst_status got %h exp 2", r); end
      do_read(32'h10, r);
      checks++;
      if (r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rst_ram got %h exp deadbeef", r); end
   endtask

   initial begin
      test_reset;
      test_ram;
      test_fifo_order;
      test_overflow;
      test_full_push_pop;
      test_back_to_back;
      test_cycle;
      test_reset_mid_drain;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
